// File: rtl/river_crossing_ctrl_pkg.sv
// Shared types and encodings for the river-crossing game controller.
// Optional move limit is enabled by defining RCC_MOVE_LIMIT_EN.
package river_pkg;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WIN   = 2'd2,
        ST_LOSE  = 2'd3
    } state_e;

    localparam logic [1:0] MV_ALONE   = 2'b00;
    localparam logic [1:0] MV_CABBAGE = 2'b01;
    localparam logic [1:0] MV_GOAT    = 2'b10;
    localparam logic [1:0] MV_WOLF    = 2'b11;

    localparam logic BANK_START = 1'b0;
    localparam logic BANK_FAR   = 1'b1;

    typedef struct packed {
        logic farmer;
        logic cabbage;
        logic goat;
        logic wolf;
    } pos_t;

endpackage

// File: rtl/river_crossing_ctrl_if.sv
// Game-side bus of river_crossing_ctrl: move handshake, positions, alarm return, result.
interface river_crossing_ctrl_if #(
    parameter int MOVE_W = 5
);
    // Handshake: master raises move_req for one cycle with move_sel valid; the
    // controller is always ready to sample it and answers one cycle later with
    // exactly one of move_ack (accepted) or move_rej (refused), unless restart
    // is high in the same cycle, in which case the request is dropped silently.
    logic              restart;
    logic              move_req;
    logic [1:0]        move_sel;
    logic              alarm_in;
    logic              farmer;
    logic              cabbage;
    logic              goat;
    logic              wolf;
    logic              move_ack;
    logic              move_rej;
    logic [MOVE_W-1:0] move_count;
    logic              win;
    logic              lose;
    logic [1:0]        dbg_state;

    modport master (
        output restart, move_req, move_sel, alarm_in,
        input  farmer, cabbage, goat, wolf, move_ack, move_rej,
        input  move_count, win, lose, dbg_state
    );

    modport slave (
        input  restart, move_req, move_sel, alarm_in,
        output farmer, cabbage, goat, wolf, move_ack, move_rej,
        output move_count, win, lose, dbg_state
    );
endinterface

// File: rtl/river_crossing_ctrl_move_decode.sv
// Combinational move decoder: legality of a move and the positions it produces.
module river_move_decode
    import river_pkg::*;
(
    input  pos_t       i_pos,
    input  logic [1:0] i_sel,
    output logic       o_legal,
    output pos_t       o_next
);

    always_comb begin
        o_legal       = 1'b1;
        o_next        = i_pos;
        o_next.farmer = ~i_pos.farmer;
        // A passenger must be on the farmer's bank to board the boat.
        case (i_sel)
            MV_CABBAGE: begin
                o_legal        = (i_pos.cabbage == i_pos.farmer);
                o_next.cabbage = ~i_pos.cabbage;
            end
            MV_GOAT: begin
                o_legal     = (i_pos.goat == i_pos.farmer);
                o_next.goat = ~i_pos.goat;
            end
            MV_WOLF: begin
                o_legal     = (i_pos.wolf == i_pos.farmer);
                o_next.wolf = ~i_pos.wolf;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/river_crossing_ctrl.sv
// River-crossing game controller: FSM, position registers, move counter, ack/rej pulses.
// Defining RCC_MOVE_LIMIT_EN makes reaching MOVE_LIMIT accepted moves a loss.
module river_crossing_ctrl
    import river_pkg::*;
#(
    parameter int MOVE_W     = 5,
    parameter int MOVE_LIMIT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    river_crossing_ctrl_if.slave bus
);

    localparam logic [1:0] S_PLAY  = ST_PLAY;
    localparam logic [1:0] S_CHECK = ST_CHECK;
    localparam logic [1:0] S_WIN   = ST_WIN;
    localparam logic [1:0] S_LOSE  = ST_LOSE;

`ifdef RCC_MOVE_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    logic [1:0]        r_state;
    pos_t              r_pos;
    logic [MOVE_W-1:0] r_count;
    logic              r_ack;
    logic              r_rej;

    logic              w_legal;
    pos_t              w_next;
    logic              w_all_far;
    logic              w_limit_hit;

    river_move_decode u_decode (
        .i_pos   (r_pos),
        .i_sel   (bus.move_sel),
        .o_legal (w_legal),
        .o_next  (w_next)
    );

    assign w_all_far   = (r_pos == {4{BANK_FAR}});
    assign w_limit_hit = (r_count >= MOVE_W'(MOVE_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_PLAY;
            r_pos   <= '0;
            r_count <= '0;
            r_ack   <= 1'b0;
            r_rej   <= 1'b0;
        end else if (bus.restart) begin
            r_state <= S_PLAY;
            r_pos   <= '0;
            r_count <= '0;
            r_ack   <= 1'b0;
            r_rej   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_rej <= 1'b0;
            case (r_state)
                S_PLAY: begin
                    if (bus.move_req) begin
                        if (w_legal) begin
                            r_pos   <= w_next;
                            r_count <= (r_count == '1) ? r_count : r_count + 1'b1;
                            r_ack   <= 1'b1;
                            r_state <= S_CHECK;
                        end else begin
                            r_rej <= 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    r_rej <= bus.move_req;
                    // alarm_in reflects the positions registered on the previous edge.
                    if (bus.alarm_in)                     r_state <= S_LOSE;
                    else if (w_all_far)                   r_state <= S_WIN;
                    else if (LIMIT_EN && w_limit_hit)     r_state <= S_LOSE;
                    else                                  r_state <= S_PLAY;
                end
                default: r_rej <= bus.move_req;
            endcase
        end
    end

    assign bus.farmer     = r_pos.farmer;
    assign bus.cabbage    = r_pos.cabbage;
    assign bus.goat       = r_pos.goat;
    assign bus.wolf       = r_pos.wolf;
    assign bus.move_ack   = r_ack;
    assign bus.move_rej   = r_rej;
    assign bus.move_count = r_count;
    assign bus.win        = (r_state == S_WIN);
    assign bus.lose       = (r_state == S_LOSE);
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_river_crossing_ctrl.sv
// Directed bench for river_crossing_ctrl: default instance plus a MOVE_LIMIT=3 instance.
module tb_river_crossing_ctrl;

    logic       clk;
    logic       rst_n;
    logic       restart;
    logic       move_req;
    logic [1:0] move_sel;

    int n_tests = 0;
    int n_fail  = 0;

    river_crossing_ctrl_if #(.MOVE_W(5)) u_if ();
    river_crossing_ctrl_if #(.MOVE_W(5)) l_if ();

    river_crossing_ctrl #(.MOVE_W(5), .MOVE_LIMIT(15)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    river_crossing_ctrl #(.MOVE_W(5), .MOVE_LIMIT(3)) l_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (l_if.slave)
    );

    assign u_if.restart  = restart;
    assign u_if.move_req = move_req;
    assign u_if.move_sel = move_sel;
    assign l_if.restart  = restart;
    assign l_if.move_req = move_req;
    assign l_if.move_sel = move_sel;

    // Downstream alarm checker: goat left with cabbage or wolf without the farmer.
    assign u_if.alarm_in = (u_if.goat != u_if.farmer) &&
                           ((u_if.goat == u_if.cabbage) || (u_if.goat == u_if.wolf));
    assign l_if.alarm_in = (l_if.goat != l_if.farmer) &&
                           ((l_if.goat == l_if.cabbage) || (l_if.goat == l_if.wolf));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues a one-cycle request; returns in the cycle where ack/rej is visible.
    task automatic do_move(input logic [1:0] sel);
        @(negedge clk);
        move_req = 1'b1;
        move_sel = sel;
        @(negedge clk);
        move_req = 1'b0;
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    function automatic logic [3:0] pos_u();
        return {u_if.farmer, u_if.cabbage, u_if.goat, u_if.wolf};
    endfunction

    logic [1:0] opt_seq [7];

    initial begin
        opt_seq = '{2'b10, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b10};
        rst_n    = 1'b0;
        restart  = 1'b0;
        move_req = 1'b0;
        move_sel = 2'b00;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_pos",   32'(pos_u()), 32'h0);
        check("rst_count", 32'(u_if.move_count), 32'd0);
        check("rst_ack",   32'(u_if.move_ack), 32'd0);
        check("rst_rej",   32'(u_if.move_rej), 32'd0);
        check("rst_win",   32'(u_if.win), 32'd0);
        check("rst_lose",  32'(u_if.lose), 32'd0);
        check("rst_state", 32'(u_if.dbg_state), 32'd0);
        rst_n = 1'b1;

        // optimal solution
        for (int i = 0; i < 7; i++) begin
            do_move(opt_seq[i]);
            check($sformatf("opt_ack%0d", i), 32'(u_if.move_ack), 32'd1);
            check($sformatf("opt_rej%0d", i), 32'(u_if.move_rej), 32'd0);
            check($sformatf("opt_chk%0d", i), 32'(u_if.dbg_state), 32'd1);
            @(negedge clk);
            check($sformatf("opt_st%0d", i), 32'(u_if.dbg_state), (i == 6) ? 32'd2 : 32'd0);
        end
        check("opt_count", 32'(u_if.move_count), 32'd7);
        check("opt_pos",   32'(pos_u()), 32'hF);
        check("opt_win",   32'(u_if.win), 32'd1);
        check("opt_lose",  32'(u_if.lose), 32'd0);
        do_move(2'b00);
        check("win_req_rej", 32'(u_if.move_rej), 32'd1);
        check("win_req_ack", 32'(u_if.move_ack), 32'd0);
        check("win_held",    32'(u_if.win), 32'd1);

        // restart clears a won game
        do_restart();
        check("rs_pos",   32'(pos_u()), 32'h0);
        check("rs_count", 32'(u_if.move_count), 32'd0);
        check("rs_win",   32'(u_if.win), 32'd0);

        // immediate loss: farmer takes the wolf, goat eats cabbage
        do_move(2'b11);
        check("loss_ack", 32'(u_if.move_ack), 32'd1);
        check("loss_pos", 32'(pos_u()), 32'h9);
        @(negedge clk);
        check("loss_lose",  32'(u_if.lose), 32'd1);
        check("loss_win",   32'(u_if.win), 32'd0);
        check("loss_count", 32'(u_if.move_count), 32'd1);
        do_move(2'b00);
        check("loss_rej",  32'(u_if.move_rej), 32'd1);
        check("loss_ack2", 32'(u_if.move_ack), 32'd0);
        @(negedge clk);
        check("loss_held", 32'(u_if.lose), 32'd1);

        // illegal move: wolf is not on the farmer's bank
        do_restart();
        do_move(2'b10);
        check("ill_ack0", 32'(u_if.move_ack), 32'd1);
        @(negedge clk);
        do_move(2'b11);
        check("ill_rej",   32'(u_if.move_rej), 32'd1);
        check("ill_ack",   32'(u_if.move_ack), 32'd0);
        check("ill_pos",   32'(pos_u()), 32'hA);
        check("ill_count", 32'(u_if.move_count), 32'd1);
        check("ill_state", 32'(u_if.dbg_state), 32'd0);
        @(negedge clk);
        check("ill_pulse", 32'(u_if.move_rej), 32'd0);

        // request during CHECK is refused
        do_restart();
        do_move(2'b10);
        move_req = 1'b1;
        move_sel = 2'b00;
        @(negedge clk);
        move_req = 1'b0;
        check("chk_rej",   32'(u_if.move_rej), 32'd1);
        check("chk_ack",   32'(u_if.move_ack), 32'd0);
        check("chk_pos",   32'(pos_u()), 32'hA);
        check("chk_count", 32'(u_if.move_count), 32'd1);

        // restart has priority over a same-cycle request
        @(negedge clk);
        restart  = 1'b1;
        move_req = 1'b1;
        move_sel = 2'b10;
        @(negedge clk);
        restart  = 1'b0;
        move_req = 1'b0;
        check("rp_ack",   32'(u_if.move_ack), 32'd0);
        check("rp_rej",   32'(u_if.move_rej), 32'd0);
        check("rp_pos",   32'(pos_u()), 32'h0);
        check("rp_count", 32'(u_if.move_count), 32'd0);

        // asynchronous reset during CHECK
        do_move(2'b10);
        check("ar_pre_ack", 32'(u_if.move_ack), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_ack",   32'(u_if.move_ack), 32'd0);
        check("ar_pos",   32'(pos_u()), 32'h0);
        check("ar_count", 32'(u_if.move_count), 32'd0);
        check("ar_state", 32'(u_if.dbg_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_move(2'b10);
        check("ar_play_ack", 32'(u_if.move_ack), 32'd1);
        check("ar_play_cnt", 32'(u_if.move_count), 32'd1);

        // move limit: goat, goat, goat
        do_restart();
        for (int i = 0; i < 3; i++) begin
            do_move(2'b10);
            check($sformatf("lim_ack%0d", i), 32'(l_if.move_ack), 32'd1);
            @(negedge clk);
        end
        check("lim_count",   32'(l_if.move_count), 32'd3);
        check("lim_u_state", 32'(u_if.dbg_state), 32'd0);
        check("lim_u_lose",  32'(u_if.lose), 32'd0);
`ifdef RCC_MOVE_LIMIT_EN
        check("lim_lose",  32'(l_if.lose), 32'd1);
        check("lim_state", 32'(l_if.dbg_state), 32'd3);
`else
        check("lim_lose",  32'(l_if.lose), 32'd0);
        check("lim_state", 32'(l_if.dbg_state), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/river_crossing_ctrl.md
# river_crossing_ctrl

Sequential game controller for the farmer/cabbage/goat/wolf river-crossing puzzle. It holds the bank position of all four characters, accepts one move request at a time, and checks each move for legality. It drives the positions into the downstream combinational alarm checker, samples that checker's alarm result, and resolves the game to WIN or LOSE.

## Interface
- `MOVE_W`, default 5: width of the move counter.
- `MOVE_LIMIT`, default 15: maximum number of accepted moves; used only when `RCC_MOVE_LIMIT_EN` is defined.
- `clk` in 1: single clock; rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `restart` in 1: synchronous game restart.
- `move_req` in 1: single-cycle move request strobe.
- `move_sel` in 2: move selector.
  - 00 = farmer alone
  - 01 = with cabbage
  - 10 = with goat
  - 11 = with wolf
- `alarm_in` in 1: alarm from the downstream checker; combinational function of `farmer`/`cabbage`/`goat`/`wolf`.
- `farmer`, `cabbage`, `goat`, `wolf` out 1 each: bank position, registered. 0 = start bank, 1 = far bank.
- `move_ack` out 1: one-cycle pulse; move accepted.
- `move_rej` out 1: one-cycle pulse; move rejected.
- `move_count` out `MOVE_W`: accepted moves; saturates at all-ones.
- `win` out 1: game won; level.
- `lose` out 1: game lost; level.

## Operation
- **Reset values:** all positions 0, `move_count` 0, `move_ack`/`move_rej`/`win`/`lose` 0, state PLAY.
- **FSM states:** PLAY, CHECK, WIN, LOSE.
- **Move legality in PLAY:**
  - sel 00 is always legal.
  - sel 01/10/11 is legal only if the selected item's position equals `farmer`.
- **Legal move:**
  - `farmer` toggles; the selected item toggles with it.
  - `move_count` increments (saturating).
  - `move_ack` pulses.
  - State goes to CHECK.
- **Illegal move:** `move_rej` pulses; no state or position change; state stays PLAY.
- **CHECK state:** one cycle; `alarm_in` is sampled against the new positions. Priority order:
  1. `alarm_in` = 1 → LOSE.
  2. All four positions = 1 → WIN.
  3. Move limit reached (macro only) → LOSE.
  4. Otherwise → PLAY.
- **Requests outside PLAY:** `move_req` in CHECK, WIN or LOSE yields `move_rej` with no other effect.
- **WIN/LOSE:** terminal states. `win`/`lose` held high until `restart` or `rst_n`.
- **`restart`:** from any state, restores all reset values on the next edge. It has priority over a same-cycle `move_req`; no ack/rej is produced for that request.
- **Reset mid-operation:** `rst_n` low in any state, including CHECK, clears everything asynchronously. No pending ack/rej survives.

## Timing
- `move_req` is sampled at edge N.
- At edge N: positions, `move_count`, and the `move_ack`/`move_rej` registers update. Ack/rej are visible in cycle N+1 for exactly one cycle.
- The alarm checker settles combinationally during cycle N+1 (the CHECK state).
- At edge N+1: `win`/`lose` update. The earliest next acceptable request is sampled at edge N+2.
- Back-to-back requests: a request at N+1 is rejected; the bench must space requests at least 2 cycles apart.
- `move_ack` and `move_rej` are never high together.
- `win` and `lose` are never high together.

## Configuration
- Macro: `RCC_MOVE_LIMIT_EN`.
- **Defined:** in CHECK, if no alarm, not won, and `move_count` ≥ `MOVE_LIMIT` → LOSE. A win on the limiting move is a WIN.
- **Undefined:** no move limit. `MOVE_LIMIT` is unused. `move_count` only saturates.

## Structure
- Package `river_pkg` holds:
  - FSM state enum (PLAY, CHECK, WIN, LOSE).
  - `move_sel` encodings: `MV_ALONE`, `MV_CABBAGE`, `MV_GOAT`, `MV_WOLF`.
  - Bank constants: `BANK_START` = 0, `BANK_FAR` = 1.
- Sub-module `river_move_decode`: combinational. Inputs: current positions and `move_sel`. Outputs: the legal flag and the next positions.
- The top level holds the FSM, position registers, counter and pulse registers.
- The alarm checker is not instantiated here. It is connected alongside in the integrating level and in the bench.

## Test plan
- **Optimal solution:** reset, then goat, alone, goat back is not used; sequence goat, alone, wolf, goat, cabbage, alone, goat, requests spaced 2 cycles apart → 7 acks, `move_count` = 7, `win` = 1 one cycle after the last ack, `lose` = 0.
- **Immediate loss:** reset, then sel 11 (wolf) → positions `farmer`=1, `wolf`=1; `alarm_in`=1 (cabbage with goat) → `lose` = 1, `move_count` = 1; a further `move_req` → `move_rej`.
- **Illegal move:** reset, goat (acked); then sel 11 with `wolf`=0, `farmer`=1 → `move_rej` pulse, positions unchanged, `move_count` = 1.
- **Restart priority:** `restart` and `move_req` (sel 10) in the same cycle → no ack/rej, all positions 0, `move_count` 0.
- **Async reset in CHECK:** assert `rst_n` low in the CHECK cycle → all outputs 0 immediately; after release, the state is PLAY.
- **Move limit:** `MOVE_LIMIT`=3, sequence goat, goat, goat → with `RCC_MOVE_LIMIT_EN` defined, `lose` = 1 after the third move; without it, the state stays PLAY and `move_count` = 3.
